ex_muldiv_unit: RTL and testbench

Iterative multiply/divide unit in the EX stage. It consumes the decoded operation and operands held in the ID/EX pipeline register and owns the architectural HI/LO registers. For MULT, MULTU, DIV and DIVU it stalls the front of the pipeline (IF/ID and ID/EX hold) until the result is written. MTHI/MTLO write HI/LO in one cycle without stalling; HI/LO are exported for the MFHI/MFLO result mux.

---
 rtl/ex_muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One radix-2 step per cycle; the front of the pipeline is stalled until the result lands.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [5:0]       alu_op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1A;
  localparam logic [5:0] OP_DIVU  = 6'h1B;
  localparam logic [5:0] OP_MTHI  = 6'h11;
  localparam logic [5:0] OP_MTLO  = 6'h13;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   acc, acc_n;
  logic [WIDTH-1:0] mq, mq_n, opnd, src;
  logic             is_div, neg_q, neg_r, div_zero;

  logic             is_md, op_signed, op_div, start;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_md     = (alu_op == OP_MULT) || (alu_op == OP_MULTU) ||
                     (alu_op == OP_DIV)  || (alu_op == OP_DIVU);
  assign op_signed = (alu_op == OP_MULT) || (alu_op == OP_DIV);
  assign op_div    = (alu_op == OP_DIV)  || (alu_op == OP_DIVU);
  assign start     = (state == IDLE) && valid && is_md;

  assign a_neg = op_signed && data1[WIDTH-1];
  assign b_neg = op_signed && data2[WIDTH-1];
  assign a_mag = a_neg ? (-data1) : data1;
  assign b_mag = b_neg ? (-data2) : data2;

  assign stall = start || (state == BUSY);
  assign busy  = (state == BUSY);

  // Single step: shift-add for multiply (acc:mq shifts right),
  // restoring shift-subtract for divide (acc:mq shifts left, quotient enters mq).
  logic [WIDTH:0] sum, shifted, diff;
  always_comb begin
    acc_n   = acc;
    mq_n    = mq;
    sum     = '0;
    shifted = '0;
    diff    = '0;
    if (is_div) begin
      shifted = {acc[WIDTH-1:0], mq[WIDTH-1]};
      diff    = shifted - {1'b0, opnd};
      if (!diff[WIDTH]) begin
        acc_n = diff;
        mq_n  = {mq[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = shifted;
        mq_n  = {mq[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum   = mq[0] ? (acc + {1'b0, opnd}) : acc;
      acc_n = {1'b0, sum[WIDTH:1]};
      mq_n  = {sum[0], mq[WIDTH-1:1]};
    end
  end

  // Sign-corrected results from the final step, written on the last BUSY edge.
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;
  always_comb begin
    prod   = {acc_n[WIDTH-1:0], mq_n};
    prod_s = neg_q ? (-prod) : prod;
    quo    = neg_q ? (-mq_n) : mq_n;
    rem    = neg_r ? (-acc_n[WIDTH-1:0]) : acc_n[WIDTH-1:0];
    res_hi = prod_s[2*WIDTH-1:WIDTH];
    res_lo = prod_s[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        res_hi = src;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      mq       <= '0;
      opnd     <= '0;
      src      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt      <= CW'(WIDTH - 1);
            acc      <= '0;
            mq       <= op_div ? a_mag : b_mag;
            opnd     <= op_div ? b_mag : a_mag;
            src      <= data1;
            is_div   <= op_div;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (data2 == '0);
          end else if (valid && alu_op == OP_MTHI) begin
            hi <= data1;
          end else if (valid && alu_op == OP_MTLO) begin
            lo <= data1;
          end
        end
        BUSY: begin
          acc <= acc_n;
          mq  <= mq_n;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit; a monitor scores each DONE cycle
// against a queue of hand-computed HI/LO results and the stall/busy lengths.
module tb_ex_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid = 1'b0;
  logic [5:0]   alu_op = '0;
  logic [W-1:0] data1 = '0, data2 = '0;
  logic         stall, busy;
  logic [W-1:0] hi, lo;

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .valid(valid), .alu_op(alu_op),
    .data1(data1), .data2(data2), .stall(stall), .busy(busy),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: the DONE cycle is the first cycle after busy falls.
  logic prev_busy = 1'b0;
  int   stall_cnt = 0;
  int   busy_cnt  = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
      stall_cnt = 0;
      busy_cnt  = 0;
    end else begin
      if (stall) stall_cnt++;
      if (busy)  busy_cnt++;
      if (prev_busy && !busy) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=result expected=none");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_hi"}, hi, e.hi);
          chk({e.name, "_lo"}, lo, e.lo);
          chk({e.name, "_done_stall"}, {31'b0, stall}, 32'd0);
          chk({e.name, "_stall_cycles"}, stall_cnt, 32'd33);
          chk({e.name, "_busy_cycles"}, busy_cnt, 32'd32);
        end
        stall_cnt = 0;
        busy_cnt  = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic wait_done(input string nm);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=busy expected=done", nm);
    end
  endtask

  task automatic do_op(input string nm, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    @(posedge clk); #1;
    valid = 1'b1; alu_op = op; data1 = a; data2 = b;
    e.name = nm; e.hi = ehi; e.lo = elo;
    sb.push_back(e);
    @(posedge clk); #1;
    valid = 1'b0;
    wait_done(nm);
  endtask

  initial begin
    #12;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy_stall", {30'b0, busy, stall}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    do_op("multu_max", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    do_op("mult_neg",  6'h18, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
    do_op("mult_min",  6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    do_op("div_neg",   6'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op("div_ovf",   6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    do_op("divu_big",  6'h1B, 32'h00000007, 32'hFFFFFFFE, 32'h00000007, 32'h00000000);
    do_op("divu_zero", 6'h1B, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF);
    do_op("div_zero",  6'h1A, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF);

    // valid held through DONE: DONE must not re-accept; next IDLE cycle does.
    begin
      exp_t e;
      @(posedge clk); #1;
      valid = 1'b1; alu_op = 6'h18; data1 = 32'h00000006; data2 = 32'hFFFFFFFE;
      e.name = "mult_hold"; e.hi = 32'hFFFFFFFF; e.lo = 32'hFFFFFFF4;
      sb.push_back(e);
      e.name = "mult_reissue";
      sb.push_back(e);
      @(posedge clk); #1;
      chk("hold_busy_hi_unchanged", hi, 32'hFFFFFFFB);
      wait_done("mult_hold");
      @(posedge clk); #1;
      chk("reissue_stall", {31'b0, stall}, 32'd1);
      @(posedge clk); #1;
      valid = 1'b0;
      wait_done("mult_reissue");
    end

    @(posedge clk); #1;
    valid = 1'b1; alu_op = 6'h13; data1 = 32'h12345678;
    chk("mtlo_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    valid = 1'b0;
    chk("mtlo_lo", lo, 32'h12345678);
    chk("mtlo_hi_kept", hi, 32'hFFFFFFFF);
    chk("mtlo_stall_after", {31'b0, stall}, 32'd0);

    // Abort a MULTU at BUSY cycle 10 with reset.
    @(posedge clk); #1;
    valid = 1'b1; alu_op = 6'h19; data1 = 32'h0000FFFF; data2 = 32'h0000FFFF;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_stall_busy", {30'b0, busy, stall}, 32'h0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    do_op("divu_100_7", 6'h1B, 32'd100, 32'd7, 32'd2, 32'd14);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
